// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (if_*) and a
// data requester (d_*). At most one transaction is outstanding. When both
// requesters contend, the grant alternates, starting with d after reset.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and address
//   if_gnt/if_rvalid/if_rdata   fetch accept pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be   data request and payload
//   d_gnt/d_rvalid/d_rdata      data accept pulse, completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   shared memory port request
//   mem_ack/mem_rdata           memory completion and read data
//   stall                       core hold
//   err                         sticky timeout flag
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT busy cycles without mem_ack. Without it, err is tied to 0.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                last_d_r;   // 1: previous grant went to d
  logic                if_win_s, d_win_s;
  logic                busy_s, expire_s, done_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BE_W-1:0]     be_r;
  logic                if_rvalid_r, d_rvalid_r;
  logic [DATA_W-1:0]   if_rdata_r, d_rdata_r;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  assign busy_s = (state_r != IDLE);
  assign done_s = busy_s && (mem_ack || expire_s);

  // Arbitration: only evaluated in IDLE; on contention the last winner yields.
  always_comb begin
    if_win_s = 1'b0;
    d_win_s  = 1'b0;
    if (state_r == IDLE) begin
      if (if_req && d_req) begin
        if (last_d_r) begin
          if_win_s = 1'b1;
        end else begin
          d_win_s = 1'b1;
        end
      end else if (d_req) begin
        d_win_s = 1'b1;
      end else if (if_req) begin
        if_win_s = 1'b1;
      end else begin
        if_win_s = 1'b0;
        d_win_s  = 1'b0;
      end
    end else begin
      if_win_s = 1'b0;
      d_win_s  = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (d_win_s) begin
          state_s = D_BUSY;
        end else if (if_win_s) begin
          state_s = IF_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and last-grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      last_d_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (d_win_s) begin
        last_d_r <= 1'b1;
      end else if (if_win_s) begin
        last_d_r <= 1'b0;
      end else begin
        last_d_r <= last_d_r;
      end
    end
  end

  // Capture the winner's payload at grant; fetches carry no write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      be_r    <= '0;
    end else if (d_win_s) begin
      addr_r  <= d_addr;
      we_r    <= d_we;
      wdata_r <= d_wdata;
      be_r    <= d_be;
    end else if (if_win_s) begin
      addr_r  <= if_addr;
      we_r    <= 1'b0;
      wdata_r <= '0;
      be_r    <= '0;
    end else begin
      addr_r  <= addr_r;
      we_r    <= we_r;
      wdata_r <= wdata_r;
      be_r    <= be_r;
    end
  end

  // Completion pulses and read data; an abort returns zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
    end else begin
      if_rvalid_r <= (state_r == IF_BUSY) && done_s;
      d_rvalid_r  <= (state_r == D_BUSY) && done_s;
      if ((state_r == IF_BUSY) && done_s) begin
        if_rdata_r <= mem_ack ? mem_rdata : '0;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if ((state_r == D_BUSY) && done_s) begin
        d_rdata_r <= mem_ack ? mem_rdata : '0;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  // mem_ack on the expiry cycle takes priority, so expiry requires no ack.
  assign expire_s = busy_s && !mem_ack && (cnt_r == CNT_W'(TIMEOUT - 1));

  // Busy-cycle counter; held at zero in IDLE so every transaction starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (busy_s && !mem_ack && !expire_s) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (expire_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign expire_s = 1'b0;
  assign err      = 1'b0;
`endif

  // Grants are combinational so the requester sees acceptance in the request
  // cycle; rst_n gating keeps them low while reset is asserted.
  assign if_gnt    = rst_n & if_win_s;
  assign d_gnt     = rst_n & d_win_s;
  assign if_rvalid = if_rvalid_r;
  assign d_rvalid  = d_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign mem_req   = busy_s;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_be    = be_r;
  assign stall     = busy_s | if_req | d_req;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder with
// programmable ack latency, a scoreboard of expected rdata per port, and
// directed scenarios (single fetch, contention, wait states, reset abort,
// timeout behaviour with and without MEM_ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall, err;

  logic          ack_m = 1'b0;
  logic [DW-1:0] rdata_m = 32'hBAD0_BAD0;
  logic          stray_ack = 1'b0;
  logic [DW-1:0] stray_rdata = 32'h0;
  logic          mem_en = 1'b1;
  int            ack_delay = 1;
  int            seen = 0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            if_rv_cnt = 0;
  int            d_rv_cnt = 0;

  typedef struct packed {
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t mon_e;

  assign mem_ack   = ack_m | stray_ack;
  assign mem_rdata = stray_ack ? stray_rdata : rdata_m;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Memory responder: ack after ack_delay waiting cycles of mem_req.
  always @(posedge clk) begin
    #1;
    if (mem_req && mem_en) begin
      seen = seen + 1;
      if (seen == ack_delay + 1) begin
        ack_m   = 1'b1;
        rdata_m = mem_model(mem_addr);
      end else begin
        ack_m   = 1'b0;
        rdata_m = 32'hBAD0_BAD0;
      end
    end else begin
      seen    = 0;
      ack_m   = 1'b0;
      rdata_m = 32'hBAD0_BAD0;
    end
  end

  // Scoreboard monitor: every rvalid pops one expected entry for its port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rvalid) begin
        if_rv_cnt++;
        if (if_q.size() == 0) check_val("if_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = if_q.pop_front();
          if (mon_e.chk) check_val("if_rdata_sb", if_rdata, mon_e.data);
        end
      end
      if (d_rvalid) begin
        d_rv_cnt++;
        if (d_q.size() == 0) check_val("d_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = d_q.pop_front();
          if (mon_e.chk) check_val("d_rdata_sb", d_rdata, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_q.delete();
    d_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output logic ig, output logic dg);
    ig = 1'b0;
    dg = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        ig = if_gnt;
        dg = d_gnt;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((if_q.size() != 0 || d_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, 64'(if_q.size() + d_q.size()), 64'd0);
    tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ig, dg;
    logic [2:0] win_pat;
    int prev_cyc, base, base_if, nb;

    // Reset state
    #2;
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_gnt", {if_gnt, d_gnt, if_rvalid, d_rvalid}, 4'h0);
    check_val("rst_err", err, 1'b0);
    do_reset();

    // Scenario 1: single fetch, ack one cycle after mem_req
    ack_delay = 1;
    if_addr = 32'h0000_0100;
    if_req = 1'b1;
    if_q.push_back({1'b1, 32'h0000_0013});
    @(negedge clk);
    check_val("s1_if_gnt_c0", if_gnt, 1'b1);
    check_val("s1_d_gnt_c0", d_gnt, 1'b0);
    check_val("s1_mem_req_c0", mem_req, 1'b0);
    check_val("s1_stall_c0", stall, 1'b1);
    tick();
    if_req = 1'b0;
    if_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("s1_mem_req_c1", mem_req, 1'b1);
    check_val("s1_mem_addr_c1", mem_addr, 32'h0000_0100);
    check_val("s1_fetch_zero_wr", {mem_we, mem_wdata, mem_be}, 37'h0);
    @(negedge clk);
    check_val("s1_mem_req_c2", mem_req, 1'b1);
    @(negedge clk);
    check_val("s1_if_rvalid_c3", if_rvalid, 1'b1);
    check_val("s1_if_rdata_c3", if_rdata, 32'h0000_0013);
    check_val("s1_mem_req_c3", mem_req, 1'b0);
    @(negedge clk);
    check_val("s1_if_rvalid_c4", if_rvalid, 1'b0);
    check_val("s1_if_rdata_hold", if_rdata, 32'h0000_0013);
    tick();

    // Scenario 2: contention from reset, alternating d / if / d
    do_reset();
    ack_delay = 1;
    if_addr = 32'h0000_0300;
    if_req = 1'b1;
    d_addr = 32'h0000_2000;
    d_we = 1'b1;
    d_wdata = 32'hDEAD_BEEF;
    d_be = 4'hF;
    d_req = 1'b1;
    win_pat = 3'b101;
    prev_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(ig, dg);
      check_val("s2_d_gnt", dg, win_pat[k]);
      check_val("s2_if_gnt", ig, !win_pat[k]);
      if (k > 0) check_val("s2_period", 64'(cyc - prev_cyc), 64'd3);
      prev_cyc = cyc;
      if (dg) d_q.push_back({1'b0, 32'h0});
      else if (ig) if_q.push_back({1'b1, mem_model(32'h0000_0300)});
      tick();
      if (k == 2) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
      @(negedge clk);
      if (win_pat[k]) begin
        check_val("s2_st_we", mem_we, 1'b1);
        check_val("s2_st_addr", mem_addr, 32'h0000_2000);
        check_val("s2_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("s2_st_be", mem_be, 4'hF);
      end else begin
        check_val("s2_if_we", mem_we, 1'b0);
        check_val("s2_if_addr", mem_addr, 32'h0000_0300);
        check_val("s2_if_wdata_be", {mem_wdata, mem_be}, 36'h0);
      end
    end
    drain("s2_drain");

    // Scenario 3: d load with 5 wait cycles
    ack_delay = 5;
    d_we = 1'b0;
    d_addr = 32'h0000_4444;
    d_wdata = 32'h1234_5678;
    d_be = 4'h3;
    d_req = 1'b1;
    d_q.push_back({1'b1, mem_model(32'h0000_4444)});
    wait_gnt(ig, dg);
    check_val("s3_d_gnt", dg, 1'b1);
    base = d_rv_cnt;
    tick();
    d_req = 1'b0;
    d_addr = 32'h0000_0BAD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("s3_mem_req_wait", mem_req, 1'b1);
      check_val("s3_mem_addr_stable", mem_addr, 32'h0000_4444);
      check_val("s3_stall", stall, 1'b1);
      check_val("s3_no_early_rvalid", d_rvalid, 1'b0);
    end
    @(negedge clk);
    check_val("s3_stall_ack", stall, 1'b1);
    @(negedge clk);
    check_val("s3_d_rvalid", d_rvalid, 1'b1);
    check_val("s3_mem_req_done", mem_req, 1'b0);
    repeat (4) @(negedge clk);
    check_val("s3_rvalid_once", 64'(d_rv_cnt - base), 64'd1);
    tick();

    // Scenario 4: reset during a fetch, then a stray ack
    ack_delay = 3;
    if_addr = 32'h0000_0500;
    if_req = 1'b1;
    if_q.push_back({1'b1, mem_model(32'h0000_0500)});
    wait_gnt(ig, dg);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check_val("s4_mem_req_pre", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    if_q.delete();
    d_q.delete();
    base_if = if_rv_cnt;
    base = d_rv_cnt;
    #1;
    check_val("s4_mem_req_rst", mem_req, 1'b0);
    check_val("s4_outs_rst", {mem_we, mem_addr, mem_wdata, mem_be}, 69'h0);
    check_val("s4_rdata_rst", {if_rdata, d_rdata}, 64'h0);
    check_val("s4_pulses_rst", {if_gnt, d_gnt, if_rvalid, d_rvalid, err}, 5'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_en = 1'b0;
    tick();
    stray_ack = 1'b1;
    stray_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    stray_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("s4_no_rvalid", {if_rvalid, d_rvalid}, 2'b00);
      check_val("s4_idle", {mem_req, stall}, 2'b00);
    end
    check_val("s4_if_rv_cnt", 64'(if_rv_cnt - base_if), 64'd0);
    check_val("s4_d_rv_cnt", 64'(d_rv_cnt - base), 64'd0);
    check_val("s4_if_rdata_kept", if_rdata, 32'h0);
    mem_en = 1'b1;
    tick();

    // Scenario 6: ack on the exact expiry cycle completes normally
    do_reset();
    ack_delay = TO - 1;
    d_we = 1'b0;
    d_addr = 32'h0000_0700;
    d_req = 1'b1;
    d_q.push_back({1'b1, mem_model(32'h0000_0700)});
    wait_gnt(ig, dg);
    tick();
    d_req = 1'b0;
    count_busy(nb);
    check_val("s6_busy_cycles", 64'(nb), 64'(TO));
    check_val("s6_d_rvalid", d_rvalid, 1'b1);
    check_val("s6_d_rdata", d_rdata, mem_model(32'h0000_0700));
    check_val("s6_err_clear", err, 1'b0);
    drain("s6_drain");

    // Scenario 5: no ack at all
    ack_delay = 1;
    mem_en = 1'b0;
    d_addr = 32'h0000_0600;
    d_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    d_q.push_back({1'b1, 32'h0});
    wait_gnt(ig, dg);
    tick();
    d_req = 1'b0;
    count_busy(nb);
    check_val("s5_timeout_cycles", 64'(nb), 64'(TO));
    check_val("s5_d_rvalid", d_rvalid, 1'b1);
    check_val("s5_d_rdata_zero", d_rdata, 32'h0);
    check_val("s5_err_set", err, 1'b1);
    mem_en = 1'b1;
    tick();
    if_addr = 32'h0000_0800;
    if_req = 1'b1;
    if_q.push_back({1'b1, mem_model(32'h0000_0800)});
    wait_gnt(ig, dg);
    tick();
    if_req = 1'b0;
    drain("s5_drain");
    check_val("s5_err_sticky", err, 1'b1);
`else
    d_q.push_back({1'b1, mem_model(32'h0000_0600)});
    wait_gnt(ig, dg);
    tick();
    d_req = 1'b0;
    nb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req) nb++;
    end
    check_val("s5_no_timeout", 64'(nb), 64'd100);
    check_val("s5_err_zero", err, 1'b0);
    mem_en = 1'b1;
    drain("s5_drain");
    check_val("s5_err_zero_end", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
